seg_mux_display: RTL and testbench

//  Time-multiplexed hex driver for NUM_DIGITS common-anode seven-segment digits sharing one segment bus.

---
 rtl/seg_mux_display_if.sv | 24 ++
 rtl/seg_mux_display.sv | 121 ++++++++++++
 tb/tb_seg_mux_display.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/seg_mux_display_if.sv
// Display bus between the switch/keypad logic and the multiplexed seven-segment driver.
// The master drives digit data and masks; the slave returns segment, anode and frame timing.
interface seg_mux_display_if #(
  parameter int NUM_DIGITS = 2
);
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_tick;

  modport master (
    output digits, dp_in, blank_mask, blink_mask,
    input  seg, dp, an, frame_tick
  );

  modport slave (
    input  digits, dp_in, blank_mask, blink_mask,
    output seg, dp, an, frame_tick
  );
endinterface

// File: rtl/seg_mux_display.sv
// Time-multiplexed hex driver for common-anode seven-segment digits on a shared segment bus,
// with frame-synchronous shadowing of digit data, dead time between slots, blank and blink masks.
module seg_mux_display #(
  parameter int NUM_DIGITS   = 2,
  parameter int REFRESH_DIV  = 24000,
  parameter int DEAD_CYCLES  = 48,
  parameter int BLINK_FRAMES = 128,
  parameter int SEG_ACT_LOW  = 1,
  parameter int AN_ACT_LOW   = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  seg_mux_display_if.slave  disp
);

  localparam int CNT_W  = $clog2(REFRESH_DIV);
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic [BCNT_W-1:0]       bcnt;
  logic                    bph;
  logic [4*NUM_DIGITS-1:0] shadow_digits;
  logic [NUM_DIGITS-1:0]   shadow_dp;

  logic [6:0]              seg_q;
  logic                    dp_q;
  logic [NUM_DIGITS-1:0]   an_q;

  logic                    slot_end;
  logic                    frame_end;
  logic                    dark;
  logic [3:0]              nibble;
  logic [NUM_DIGITS-1:0]   an_sel;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] p;
    case (v)
      4'h0: p = 7'h3F;
      4'h1: p = 7'h06;
      4'h2: p = 7'h5B;
      4'h3: p = 7'h4F;
      4'h4: p = 7'h66;
      4'h5: p = 7'h6D;
      4'h6: p = 7'h7D;
      4'h7: p = 7'h07;
      4'h8: p = 7'h7F;
      4'h9: p = 7'h6F;
      4'hA: p = 7'h77;
      4'hB: p = 7'h7C;
      4'hC: p = 7'h39;
      4'hD: p = 7'h5E;
      4'hE: p = 7'h79;
      4'hF: p = 7'h71;
    endcase
    return p;
  endfunction

  assign slot_end  = (cnt == CNT_W'(REFRESH_DIV - 1));
  assign frame_end = slot_end && (idx == IDX_W'(NUM_DIGITS - 1));
  assign dark      = disp.blank_mask[idx] | (disp.blink_mask[idx] & bph);
  assign nibble    = shadow_digits[idx*4 +: 4];

  always_comb begin
    an_sel      = '0;
    an_sel[idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Digit data is only taken at frame end so every digit of a frame shows the same snapshot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_digits <= '0;
      shadow_dp     <= '0;
      bcnt          <= '0;
      bph           <= 1'b0;
    end else if (frame_end) begin
      shadow_digits <= disp.digits;
      shadow_dp     <= disp.dp_in;
      if (bcnt == BCNT_W'(BLINK_FRAMES - 1)) begin
        bcnt <= '0;
        bph  <= ~bph;
      end else begin
        bcnt <= bcnt + 1'b1;
      end
    end
  end

  // Segments switch only at slot start, while the anodes are held off by the dead time.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_q <= '0;
      dp_q  <= 1'b0;
      an_q  <= '0;
    end else begin
      if (cnt == '0) begin
        seg_q <= dark ? 7'h00 : seg_decode(nibble);
        dp_q  <= ~dark & shadow_dp[idx];
      end
      an_q <= (cnt >= CNT_W'(DEAD_CYCLES) && !dark) ? an_sel : '0;
    end
  end

  assign disp.seg        = (SEG_ACT_LOW != 0) ? ~seg_q : seg_q;
  assign disp.dp         = (SEG_ACT_LOW != 0) ? ~dp_q : dp_q;
  assign disp.an         = (AN_ACT_LOW != 0) ? ~an_q : an_q;
  assign disp.frame_tick = frame_end;

endmodule

// File: tb/tb_seg_mux_display.sv
// Directed self-checking bench for seg_mux_display with a short refresh period
// (2 digits, 8-cycle slots, 2 dead cycles, 4-frame blink half-period, active-low outputs).
module tb_seg_mux_display;

  logic clk = 1'b0;
  logic reset_n;

  seg_mux_display_if #(.NUM_DIGITS(2)) bus ();

  seg_mux_display #(
    .NUM_DIGITS  (2),
    .REFRESH_DIV (8),
    .DEAD_CYCLES (2),
    .BLINK_FRAMES(4),
    .SEG_ACT_LOW (1),
    .AN_ACT_LOW  (1)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .disp   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: t counts clock edges since reset release.
  int         t;
  logic [7:0] m_dig;
  logic [1:0] m_dpin;
  int         m_bcnt;
  logic       m_bph;
  logic [6:0] m_seg;
  logic       m_dp;
  logic [1:0] m_an;
  logic [1:0] prev_an;
  logic [6:0] prev_seg;

  function automatic logic [6:0] dec(input logic [3:0] v);
    logic [6:0] p;
    case (v)
      4'h0: p = 7'h3F;  4'h1: p = 7'h06;  4'h2: p = 7'h5B;  4'h3: p = 7'h4F;
      4'h4: p = 7'h66;  4'h5: p = 7'h6D;  4'h6: p = 7'h7D;  4'h7: p = 7'h07;
      4'h8: p = 7'h7F;  4'h9: p = 7'h6F;  4'hA: p = 7'h77;  4'hB: p = 7'h7C;
      4'hC: p = 7'h39;  4'hD: p = 7'h5E;  4'hE: p = 7'h79;  4'hF: p = 7'h71;
    endcase
    return p;
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $display("[TB] FAIL %s at t=%0d: observed=%0h expected=%0h", tag, t, obs, exp);
      $error("[TB] check %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic [1:0] dpi,
                               input logic [1:0] blank, input logic [1:0] blink);
    bus.digits     = d;
    bus.dp_in      = dpi;
    bus.blank_mask = blank;
    bus.blink_mask = blink;
  endtask

  task automatic resetModel();
    t      = 0;
    m_dig  = 8'h00;
    m_dpin = 2'b00;
    m_bcnt = 0;
    m_bph  = 1'b0;
    m_seg  = 7'h00;
    m_dp   = 1'b0;
    m_an   = 2'b00;
  endtask

  // One clock: predict the registered outputs from the state before the edge, then compare.
  task automatic step();
    int   p;
    int   id;
    logic dk;
    p  = t % 8;
    id = (t / 8) % 2;
    dk = bus.blank_mask[id] | (bus.blink_mask[id] & m_bph);
    if (p == 0) begin
      m_seg = dk ? 7'h00 : dec(m_dig[id*4 +: 4]);
      m_dp  = !dk && m_dpin[id];
    end
    m_an = (p >= 2 && !dk) ? ((id == 0) ? 2'b01 : 2'b10) : 2'b00;
    if (t % 16 == 15) begin
      m_dig  = bus.digits;
      m_dpin = bus.dp_in;
      if (m_bcnt == 3) begin
        m_bcnt = 0;
        m_bph  = ~m_bph;
      end else begin
        m_bcnt++;
      end
    end
    t++;
    prev_an  = bus.an;
    prev_seg = bus.seg;
    @(posedge clk);
    @(negedge clk);
    checkOutput("seg", {1'b0, bus.seg}, {1'b0, ~m_seg});
    checkOutput("dp", {7'b0, bus.dp}, {7'b0, ~m_dp});
    checkOutput("an", {6'b0, bus.an}, {6'b0, ~m_an});
    checkOutput("frame_tick", {7'b0, bus.frame_tick}, {7'b0, (t % 16 == 15)});
    if (prev_an != 2'b11 && bus.an != 2'b11)
      checkOutput("seg_stable_while_lit", {1'b0, bus.seg}, {1'b0, prev_seg});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    applyStimulus(8'h00, 2'b00, 2'b00, 2'b00);
    resetModel();
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    checkOutput("reset_an", {6'b0, bus.an}, 8'h03);
    checkOutput("reset_seg", {1'b0, bus.seg}, 8'h7F);
    checkOutput("reset_dp", {7'b0, bus.dp}, 8'h01);
    checkOutput("reset_frame_tick", {7'b0, bus.frame_tick}, 8'h00);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    resetModel();

    $display("[TB] first digit after reset");
    run(3);
    checkOutput("first_seg", {1'b0, bus.seg}, {1'b0, ~7'h3F});
    checkOutput("first_an", {6'b0, bus.an}, 8'h02);

    $display("[TB] shadow load");
    run(2);
    applyStimulus(8'hA5, 2'b00, 2'b00, 2'b00);
    run(14);
    checkOutput("frame1_digit0", {1'b0, bus.seg}, {1'b0, ~7'h6D});
    checkOutput("frame1_an0", {6'b0, bus.an}, 8'h02);
    run(8);
    checkOutput("frame1_digit1", {1'b0, bus.seg}, {1'b0, ~7'h77});
    checkOutput("frame1_an1", {6'b0, bus.an}, 8'h01);
    run(4);
    checkOutput("frame1_tick", {7'b0, bus.frame_tick}, 8'h01);
    run(1);

    $display("[TB] blink");
    applyStimulus(8'h88, 2'b00, 2'b00, 2'b01);
    run(35);
    checkOutput("blink_off_an", {6'b0, bus.an}, 8'h03);
    checkOutput("blink_off_seg", {1'b0, bus.seg}, 8'h7F);
    run(8);
    checkOutput("blink_digit1_seg", {1'b0, bus.seg}, 8'h00);
    checkOutput("blink_digit1_an", {6'b0, bus.an}, 8'h01);
    run(56);
    checkOutput("blink_on_an", {6'b0, bus.an}, 8'h02);
    checkOutput("blink_on_seg", {1'b0, bus.seg}, 8'h00);

    $display("[TB] hex and dp sweep");
    applyStimulus(8'h88, 2'b10, 2'b00, 2'b00);
    run(13);
    for (int v = 0; v <= 16; v++) begin
      if (v < 16) bus.digits = {v[3:0], v[3:0]};
      run(3);
      if (v > 0) begin
        checkOutput("sweep_seg0", {1'b0, bus.seg}, {1'b0, ~dec(4'(v - 1))});
        checkOutput("sweep_dp0", {7'b0, bus.dp}, 8'h01);
      end
      run(8);
      if (v > 0) begin
        checkOutput("sweep_seg1", {1'b0, bus.seg}, {1'b0, ~dec(4'(v - 1))});
        checkOutput("sweep_dp1", {7'b0, bus.dp}, 8'h00);
      end
      run(5);
    end

    $display("[TB] blank mask");
    applyStimulus(8'hFF, 2'b10, 2'b10, 2'b00);
    run(27);
    checkOutput("blank_an", {6'b0, bus.an}, 8'h03);
    checkOutput("blank_seg", {1'b0, bus.seg}, 8'h7F);
    checkOutput("blank_dp", {7'b0, bus.dp}, 8'h01);

    $display("[TB] reset mid-scan");
    applyStimulus(8'hFF, 2'b10, 2'b00, 2'b00);
    run(17);
    checkOutput("pre_reset_an", {6'b0, bus.an}, 8'h01);
    reset_n = 1'b0;
    #1;
    checkOutput("midreset_an", {6'b0, bus.an}, 8'h03);
    checkOutput("midreset_seg", {1'b0, bus.seg}, 8'h7F);
    checkOutput("midreset_dp", {7'b0, bus.dp}, 8'h01);
    checkOutput("midreset_frame_tick", {7'b0, bus.frame_tick}, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    resetModel();
    run(3);
    checkOutput("restart_seg0", {1'b0, bus.seg}, {1'b0, ~7'h3F});
    checkOutput("restart_an0", {6'b0, bus.an}, 8'h02);
    run(8);
    checkOutput("restart_seg1", {1'b0, bus.seg}, {1'b0, ~7'h3F});
    checkOutput("restart_dp1", {7'b0, bus.dp}, 8'h01);
    checkOutput("restart_an1", {6'b0, bus.an}, 8'h01);
    run(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
